turn_ctrl: RTL and testbench
============================

# turn_ctrl

Turn controller for the chicken board game. Sits directly upstream of the per-player position counters and produces their advance enables (`p_da[i]`). On each debounced button press it:
- takes the card the current player flipped;
- compares that card's picture with the board tile one step ahead of the player;
- on a match, pulses that player's advance enable;
- on a miss, hands the turn to the next player.

## Interface
Parameters:
- `BOARD_LEN`, 24, number of board tiles; positions run 0..BOARD_LEN-1 and wrap.
- `NUM_CARDS`, 12, number of face-down picture cards.
- `POS_W`, 5, position width.
- `CARD_W`, 4, card and tile picture code width.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `num_players`  in  5  player count N; legal values 2..4; any other value behaves as 2.
- `btn`  in  1  raw, asynchronous flip button level.
- `card_sel`  in  CARD_W  index of the card being flipped.
- `pos_cur`  in  POS_W  position of the current player, muxed externally using `cur_player`.
- `tile_pic`  in  CARD_W  picture at `tile_addr`; comes from a synchronous board ROM with one-cycle read latency.
- `tile_addr`  out  POS_W  tile one step ahead of the current player.
- `cur_player`  out  2  player whose turn it is (0..N-1).
- `p_da`  out  4  one-cycle advance pulse, one bit per player.
- `miss`  out  1  one-cycle pulse when a turn ends.
- `flipped`  out  NUM_CARDS  mask of cards currently face up.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Button input:** `btn` passes through a 2-flop synchronizer and then a rising-edge detector. The result, `press`, is a one-cycle pulse.
- **IDLE:**
  - A press is accepted only when `card_sel < NUM_CARDS` and `flipped[card_sel]` is 0.
  - On acceptance: latch `card_sel` into `card_q`, set `flipped[card_sel]`, register `tile_addr` (= 0 if `pos_cur == BOARD_LEN-1`, else `pos_cur+1`), then go to LOOKUP.
  - A press that is not accepted is ignored; the FSM stays in IDLE and no output changes.
- **LOOKUP:** wait one cycle for the ROM, then go to COMPARE.
- **COMPARE:** if `tile_pic == card_q` go to ADVANCE, otherwise go to MISS.
- **ADVANCE:**
  - `p_da[cur_player]` = 1 for exactly this cycle; all other `p_da` bits stay 0.
  - Return to IDLE. The same player keeps the turn and `flipped` is unchanged.
- **MISS:**
  - `miss` = 1 for this cycle and `flipped` is cleared to 0.
  - `cur_player` becomes `cur_player+1`, wrapping to 0 when it reaches N-1.
  - Return to IDLE.
- **Presses outside IDLE** are dropped, not queued.
- **Change of `num_players`:** takes effect at the next rotation. If `cur_player >= N` at that rotation, it wraps to 0.
- **Reset values:**
  - state IDLE, `cur_player` 0, `flipped` 0, `p_da` 0, `miss` 0, `tile_addr` 0, `card_q` 0, `busy` 0;
  - synchronizer and edge-detector flops are 0.
- **Reset mid-turn:** asserting `rst_n` low in any state immediately forces all reset values; no partial pulse is emitted.

## Timing
- Let cycle t be the cycle in which `press` is high in IDLE:
  - t+1: LOOKUP; `tile_addr` valid and `busy` = 1.
  - t+2: COMPARE; `tile_pic` valid.
  - t+3: ADVANCE or MISS; the `p_da`/`miss` pulse appears here.
  - t+4: back in IDLE; `cur_player` already updated after a miss.
- Latency from the `btn` rising edge to `press` is 2–3 clocks, depending on synchronizer phase.
- Minimum spacing between accepted presses is 4 cycles. In practice human presses are far apart.
- `p_da` is a registered output, high for one `clk` cycle. The downstream counter must sample it in that same cycle.
- Every output is registered.

## Structure
- `game_pkg` holds:
  - `BOARD_LEN`, `NUM_CARDS`, `POS_W`, `CARD_W`;
  - the state enum (IDLE, LOOKUP, COMPARE, ADVANCE, MISS);
  - a `next_pos` wrap function shared with the position counters.
- Sub-module `btn_edge_sync` contains the 2-flop synchronizer plus the rising-edge pulse generator. It is reused for the reset and start buttons.
- The rest of the design is a single FSM plus the `flipped`, `card_q`, `tile_addr` and `cur_player` registers.

## Test plan
- **Reset mid-turn:** N=2; release reset, then press with `card_sel`=3, `pos_cur`=5, `tile_pic`=3 → `tile_addr`=6, `p_da`=0001 for one cycle at t+3, `cur_player` stays 0, `flipped`=0x008. Then hold `rst_n` low during LOOKUP of the next press → all outputs 0 and state IDLE.
- **Wrap and re-flip:** `pos_cur`=23, `card_sel`=7, `tile_pic`=7 → `tile_addr`=0, `p_da[0]` pulse. Then press again with `card_sel`=7 → ignored; `busy` stays 0.
- **Miss and rotation:** N=3, player 2's turn, `tile_pic`≠`card_q` → `miss` pulse, `flipped`=0, `cur_player`=0, no `p_da` bit set.
- **Rotation across all players:** N=4, four consecutive misses → `cur_player` sequence 1, 2, 3, 0. Then set `num_players`=9 → treated as N=2; the next miss from 0 gives 1 and the following gives 0.
- **Dropped press:** a second press pulse arriving during COMPARE → dropped; exactly one `p_da` pulse total.
- **Out-of-range card:** `card_sel`=12 → ignored; `flipped` unchanged and no state change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, FSM state encoding and the board-position wrap helper for
// the chicken board game logic.
package game_pkg;

  localparam int BOARD_LEN = 24;
  localparam int NUM_CARDS = 12;
  localparam int POS_W     = 5;
  localparam int CARD_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_COMPARE,
    ST_ADVANCE,
    ST_MISS
  } state_e;

  // Step one tile forward around the looped board.
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] pos,
                                                input int               board_len);
    if (int'(pos) == board_len - 1) begin
      return '0;
    end
    return pos + 1'b1;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; turns an
// asynchronous button level into a single-cycle press pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign press_o = sync_q & ~prev_q;

endmodule

// File: rtl/turn_ctrl.sv
// Turn controller: matches the flipped card against the tile ahead of the
// current player, pulses that player's advance enable or rotates the turn.
module turn_ctrl #(
  parameter int BOARD_LEN = game_pkg::BOARD_LEN,
  parameter int NUM_CARDS = game_pkg::NUM_CARDS,
  parameter int POS_W     = game_pkg::POS_W,
  parameter int CARD_W    = game_pkg::CARD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           num_players,
  input  logic                 btn,
  input  logic [CARD_W-1:0]    card_sel,
  input  logic [POS_W-1:0]     pos_cur,
  input  logic [CARD_W-1:0]    tile_pic,
  output logic [POS_W-1:0]     tile_addr,
  output logic [1:0]           cur_player,
  output logic [3:0]           p_da,
  output logic                 miss,
  output logic [NUM_CARDS-1:0] flipped,
  output logic                 busy
);

  import game_pkg::*;

  logic                 press;
  state_e               state_q;
  logic [CARD_W-1:0]    card_q;
  logic [NUM_CARDS-1:0] flipped_q;
  logic [POS_W-1:0]     tile_addr_q;
  logic [1:0]           cur_player_q;
  logic [3:0]           p_da_q;
  logic                 miss_q;
  logic                 busy_q;

  logic [2:0]           n_eff;
  logic                 accept;
  logic [1:0]           rot_next;

  btn_edge_sync u_btn_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn),
    .press_o (press)
  );

  // Illegal player counts fall back to a two-player game.
  always_comb begin
    n_eff = 3'd2;
    if (num_players >= 5'd2 && num_players <= 5'd4) begin
      n_eff = num_players[2:0];
    end
  end

  always_comb begin
    accept = 1'b0;
    if (press && (32'(card_sel) < NUM_CARDS)) begin
      accept = ~flipped_q[card_sel];
    end
  end

  // A stale cur_player beyond a shrunken player count also wraps to 0 here.
  always_comb begin
    rot_next = cur_player_q + 2'd1;
    if ({1'b0, cur_player_q} >= (n_eff - 3'd1)) begin
      rot_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      card_q       <= '0;
      flipped_q    <= '0;
      tile_addr_q  <= '0;
      cur_player_q <= '0;
      p_da_q       <= '0;
      miss_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      p_da_q <= '0;
      miss_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            card_q              <= card_sel;
            flipped_q[card_sel] <= 1'b1;
            tile_addr_q         <= next_pos(pos_cur, BOARD_LEN);
            state_q             <= ST_LOOKUP;
            busy_q              <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          state_q <= ST_COMPARE;
        end
        ST_COMPARE: begin
          if (tile_pic == card_q) begin
            p_da_q  <= 4'b0001 << cur_player_q;
            state_q <= ST_ADVANCE;
          end else begin
            miss_q    <= 1'b1;
            flipped_q <= '0;
            state_q   <= ST_MISS;
          end
        end
        ST_ADVANCE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_MISS: begin
          cur_player_q <= rot_next;
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tile_addr  = tile_addr_q;
  assign cur_player = cur_player_q;
  assign p_da       = p_da_q;
  assign miss       = miss_q;
  assign flipped    = flipped_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed testbench for turn_ctrl with hand-computed expectations.
module tb_turn_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  num_players;
  logic        btn;
  logic [3:0]  card_sel;
  logic [4:0]  pos_cur;
  logic [3:0]  tile_pic;
  logic [4:0]  tile_addr;
  logic [1:0]  cur_player;
  logic [3:0]  p_da;
  logic        miss;
  logic [11:0] flipped;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_ctrl #(.BOARD_LEN(24), .NUM_CARDS(12), .POS_W(5), .CARD_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .num_players (num_players),
    .btn         (btn),
    .card_sel    (card_sel),
    .pos_cur     (pos_cur),
    .tile_pic    (tile_pic),
    .tile_addr   (tile_addr),
    .cur_player  (cur_player),
    .p_da        (p_da),
    .miss        (miss),
    .flipped     (flipped),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge where an accepted press moves the FSM to LOOKUP.
  task automatic start_press(input logic [3:0] card, input logic [4:0] pos);
    @(negedge clk);
    card_sel = card;
    pos_cur  = pos;
    btn      = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 1'b0; num_players = 5'd2;
    card_sel = '0; pos_cur = '0; tile_pic = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (cur_player !== 2'd0) begin errors++; $display("FAIL reset_player got %0d exp 0", cur_player); end
    checks++; if (flipped !== 12'h000) begin errors++; $display("FAIL reset_flipped got %h exp 000", flipped); end
    checks++; if (p_da !== 4'b0000) begin errors++; $display("FAIL reset_p_da got %b exp 0000", p_da); end
    checks++; if (miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %0b exp 0", miss); end
    checks++; if (tile_addr !== 5'd0) begin errors++; $display("FAIL reset_tile_addr got %0d exp 0", tile_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_advance_then_reset();
    int pulses;
    num_players = 5'd2;
    tile_pic    = 4'd3;
    start_press(4'd3, 5'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL adv_lookup_busy got %0b exp 1", busy); end
    checks++; if (tile_addr !== 5'd6) begin errors++; $display("FAIL adv_tile_addr got %0d exp 6", tile_addr); end
    tick();
    checks++; if (p_da !== 4'b0000) begin errors++; $display("FAIL adv_early_p_da got %b exp 0000", p_da); end
    tick();
    checks++; if (p_da !== 4'b0001) begin errors++; $display("FAIL adv_p_da got %b exp 0001", p_da); end
    checks++; if (miss !== 1'b0) begin errors++; $display("FAIL adv_miss got %0b exp 0", miss); end
    tick();
    checks++; if (p_da !== 4'b0000) begin errors++; $display("FAIL adv_p_da_end got %b exp 0000", p_da); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL adv_idle_busy got %0b exp 0", busy); end
    checks++; if (cur_player !== 2'd0) begin errors++; $display("FAIL adv_player got %0d exp 0", cur_player); end
    checks++; if (flipped !== 12'h008) begin errors++; $display("FAIL adv_flipped got %h exp 008", flipped); end
    start_press(4'd4, 5'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %0b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
    checks++; if (flipped !== 12'h000) begin errors++; $display("FAIL midrst_flipped got %h exp 000", flipped); end
    checks++; if (tile_addr !== 5'd0) begin errors++; $display("FAIL midrst_tile_addr got %0d exp 0", tile_addr); end
    checks++; if (cur_player !== 2'd0) begin errors++; $display("FAIL midrst_player got %0d exp 0", cur_player); end
    checks++; if ({p_da, miss} !== 5'b0) begin errors++; $display("FAIL midrst_pulses got %b exp 00000", {p_da, miss}); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      tick();
      if (p_da !== 4'b0000 || miss !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles exp 0", pulses); end
  endtask

  task automatic test_wrap_reflip();
    int busy_cycles;
    tile_pic = 4'd7;
    start_press(4'd7, 5'd23);
    checks++; if (tile_addr !== 5'd0) begin errors++; $display("FAIL wrap_tile_addr got %0d exp 0", tile_addr); end
    tick(); tick();
    checks++; if (p_da !== 4'b0001) begin errors++; $display("FAIL wrap_p_da got %b exp 0001", p_da); end
    tick();
    checks++; if (flipped !== 12'h080) begin errors++; $display("FAIL wrap_flipped got %h exp 080", flipped); end
    start_press(4'd7, 5'd23);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    repeat (4) begin
      tick();
      if (busy !== 1'b0 || p_da !== 4'b0000) busy_cycles++;
    end
    checks++; if (busy_cycles != 0) begin errors++; $display("FAIL reflip_busy got %0d active cycles exp 0", busy_cycles); end
    checks++; if (flipped !== 12'h080) begin errors++; $display("FAIL reflip_flipped got %h exp 080", flipped); end
  endtask

  task automatic test_out_of_range();
    int busy_cycles;
    start_press(4'd12, 5'd10);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    repeat (4) begin
      tick();
      if (busy !== 1'b0) busy_cycles++;
    end
    checks++; if (busy_cycles != 0) begin errors++; $display("FAIL oor_busy got %0d busy cycles exp 0", busy_cycles); end
    checks++; if (flipped !== 12'h080) begin errors++; $display("FAIL oor_flipped got %h exp 080", flipped); end
    checks++; if (tile_addr !== 5'd0) begin errors++; $display("FAIL oor_tile_addr got %0d exp 0", tile_addr); end
  endtask

  // btn sampled 1,0,1 on three successive edges: press pulses at t and t+2 (COMPARE).
  task automatic test_dropped_press();
    int busy_cycles;
    int p_cnt;
    logic [3:0] p_seen;
    tile_pic = 4'd1;
    pos_cur  = 5'd2;
    card_sel = 4'd1;
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    tick();
    card_sel = 4'd2;
    btn      = 1'b0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    p_cnt  = 0;
    p_seen = '0;
    repeat (8) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
      if (p_da !== 4'b0000) begin p_cnt++; p_seen = p_da; end
    end
    checks++; if (p_cnt != 1) begin errors++; $display("FAIL drop_pulse_count got %0d exp 1", p_cnt); end
    checks++; if (p_seen !== 4'b0001) begin errors++; $display("FAIL drop_p_da got %b exp 0001", p_seen); end
    checks++; if (busy_cycles != 3) begin errors++; $display("FAIL drop_busy_cycles got %0d exp 3", busy_cycles); end
    checks++; if (flipped !== 12'h082) begin errors++; $display("FAIL drop_flipped got %h exp 082", flipped); end
  endtask

  task automatic test_miss_rotation();
    logic [1:0] exp_seq [3] = '{2'd1, 2'd2, 2'd0};
    num_players = 5'd3;
    tile_pic    = 4'd15;
    for (int i = 0; i < 3; i++) begin
      start_press(4'd0, 5'd0);
      tick(); tick();
      checks++; if (miss !== 1'b1) begin errors++; $display("FAIL miss3_pulse[%0d] got %0b exp 1", i, miss); end
      checks++; if (p_da !== 4'b0000) begin errors++; $display("FAIL miss3_p_da[%0d] got %b exp 0000", i, p_da); end
      checks++; if (flipped !== 12'h000) begin errors++; $display("FAIL miss3_flipped[%0d] got %h exp 000", i, flipped); end
      tick();
      checks++; if (cur_player !== exp_seq[i]) begin errors++; $display("FAIL miss3_player[%0d] got %0d exp %0d", i, cur_player, exp_seq[i]); end
      checks++; if (miss !== 1'b0) begin errors++; $display("FAIL miss3_end[%0d] got %0b exp 0", i, miss); end
    end
  endtask

  task automatic test_rotation_all();
    logic [1:0] exp4 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] exp2 [2] = '{2'd1, 2'd0};
    num_players = 5'd4;
    tile_pic    = 4'd15;
    for (int i = 0; i < 4; i++) begin
      start_press(4'd5, 5'd9);
      repeat (3) tick();
      checks++; if (cur_player !== exp4[i]) begin errors++; $display("FAIL rot4_player[%0d] got %0d exp %0d", i, cur_player, exp4[i]); end
    end
    num_players = 5'd9;
    for (int i = 0; i < 2; i++) begin
      start_press(4'd5, 5'd9);
      repeat (3) tick();
      checks++; if (cur_player !== exp2[i]) begin errors++; $display("FAIL rot9_player[%0d] got %0d exp %0d", i, cur_player, exp2[i]); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish exp completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_advance_then_reset();
    test_wrap_reflip();
    test_out_of_range();
    test_dropped_press();
    test_miss_rotation();
    test_rotation_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
